// File: rtl/dvp_pattern_tx_pkg.sv
// Shared definitions for the DVP pattern transmitter.
//   cam_state_e : frame sequencer states
//   cam_pat_e   : test pattern codes (pattern_sel encoding)
//   pix_byte    : splits a 12-bit RGB444 pixel into its DVP byte pair
package dvp_pattern_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_VSYNC  = 3'd1,
    ST_VBP    = 3'd2,
    ST_ACTIVE = 3'd3,
    ST_VFP    = 3'd4
  } cam_state_e;

  typedef enum logic [1:0] {
    PAT_BARS  = 2'd0,
    PAT_RAMP  = 2'd1,
    PAT_SOLID = 2'd2,
    PAT_CNT   = 2'd3
  } cam_pat_e;

  // Byte order matches the capture packer: byte0={0,B}, byte1={G,R}.
  function automatic logic [7:0] pix_byte(input logic [11:0] w, input logic hi);
    return hi ? {w[7:4], w[11:8]} : {4'h0, w[3:0]};
  endfunction

endpackage

// File: rtl/dvp_pattern_tx_if.sv
// DVP camera bus: frame sync, line valid and pixel byte.
//   master : driven by the sensor side (dvp_pattern_tx)
//   slave  : observed by the capture side
interface dvp_pattern_tx_if;
  logic       cam_vsynk;
  logic       cam_href;
  logic [7:0] cam_data;

  modport master (output cam_vsynk, output cam_href, output cam_data);
  modport slave  (input  cam_vsynk, input  cam_href, input  cam_data);
endinterface

// File: rtl/dvp_pattern_tx_gen.sv
// Combinational test pattern generator.
//   x, y   : pixel column / active line (zero-extended)
//   bar    : colour bar index for column x
//   pat    : selected pattern
//   solid  : solid colour {R,G,B}
//   pix    : resulting RGB444 pixel {R,G,B}
module dvp_pattern_gen
  import dvp_pattern_tx_pkg::*;
(
  input  logic [11:0] x,
  input  logic [11:0] y,
  input  logic [2:0]  bar,
  input  cam_pat_e    pat,
  input  logic [11:0] solid,
  output logic [11:0] pix
);

  always_comb begin
    pix = '0;
    case (pat)
      PAT_BARS:  pix = {{4{bar[2]}}, {4{bar[1]}}, {4{bar[0]}}};
      PAT_RAMP:  pix = {x[3:0], x[7:4], y[3:0]};
      PAT_SOLID: pix = solid;
      PAT_CNT:   pix = x + y;   // 12-bit sum wraps mod 4096
      default:   pix = '0;
    endcase
  end

endmodule

// File: rtl/dvp_pattern_tx.sv
// OV7670-style DVP sensor emulator: timed frames of RGB444 test patterns,
// two bytes per pixel, one byte per clk.
//   clk, rstn    : clock / async active-low reset
//   enable       : start and keep running frames (sampled at frame boundaries)
//   pattern_sel  : 0 bars, 1 ramp, 2 solid, 3 counter (latched at frame start)
//   solid_rgb    : solid colour for pattern 2 (latched at frame start)
//   cam          : DVP bus (cam_vsynk, cam_href, cam_data)
//   frame_done   : 1-clk pulse on the last clk of the front porch
//   frame_cnt    : completed frames, wraps silently
//   busy         : frame in progress
// All outputs are registered from the sequencer state, so they trail the
// state register by one clk.
module dvp_pattern_tx
  import dvp_pattern_tx_pkg::*;
#(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_BLANK  = 288,
  parameter int unsigned V_SYNC   = 3,
  parameter int unsigned V_BP     = 17,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  enable,
  input  logic [1:0]            pattern_sel,
  input  logic [11:0]           solid_rgb,
  dvp_pattern_tx_if.master      cam,
  output logic                  frame_done,
  output logic [15:0]           frame_cnt,
  output logic                  busy
);

  localparam int unsigned LINE_LEN = 2 * H_ACTIVE + H_BLANK;
  localparam int unsigned HREF_LEN = 2 * H_ACTIVE;
  localparam int unsigned BAR_W    = H_ACTIVE / 8;
  localparam int          HW       = $clog2(LINE_LEN);
  localparam int          VW       = $clog2(V_SYNC + V_BP + V_ACTIVE + V_FP);
  localparam int          BW       = $clog2(BAR_W) + 1;

  cam_state_e      state_q, state_d;
  logic [HW-1:0]   hcnt;
  logic [VW-1:0]   vcnt;
  logic [VW-1:0]   lines_m1;
  logic            line_end;
  logic            state_last;
  cam_pat_e        pat_q;
  logic [11:0]     solid_q;
  logic [BW-1:0]   bar_pix;
  logic [2:0]      bar_idx;
  logic [11:0]     pix;
  logic            in_href;

  logic            vsynk_d, href_d, done_d, busy_d;
  logic [7:0]      data_d;

  always_comb begin
    lines_m1 = '0;
    case (state_q)
      ST_VSYNC:  lines_m1 = VW'(V_SYNC - 1);
      ST_VBP:    lines_m1 = VW'(V_BP - 1);
      ST_ACTIVE: lines_m1 = VW'(V_ACTIVE - 1);
      ST_VFP:    lines_m1 = VW'(V_FP - 1);
      default:   lines_m1 = '0;
    endcase
  end

  assign line_end   = (hcnt == HW'(LINE_LEN - 1));
  assign state_last = line_end && (vcnt == lines_m1);
  assign in_href    = (state_q == ST_ACTIVE) && (hcnt < HW'(HREF_LEN));

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (enable)     state_d = ST_VSYNC;
      ST_VSYNC:  if (state_last) state_d = ST_VBP;
      ST_VBP:    if (state_last) state_d = ST_ACTIVE;
      ST_ACTIVE: if (state_last) state_d = ST_VFP;
      ST_VFP:    if (state_last) state_d = enable ? ST_VSYNC : ST_IDLE;
      default:                   state_d = ST_IDLE;
    endcase
  end

  // Timing counters, frame-start latches and the bar counter
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      hcnt    <= '0;
      vcnt    <= '0;
      pat_q   <= PAT_BARS;
      solid_q <= '0;
      bar_pix <= '0;
      bar_idx <= '0;
    end else begin
      if (state_q == ST_IDLE || line_end) hcnt <= '0;
      else                                hcnt <= hcnt + HW'(1);

      if (state_d != state_q) vcnt <= '0;
      else if (line_end)      vcnt <= vcnt + VW'(1);

      if (state_q != ST_VSYNC && state_d == ST_VSYNC) begin
        pat_q   <= cam_pat_e'(pattern_sel);
        solid_q <= solid_rgb;
      end

      // Bar index tracks x / BAR_W without a divider: it advances after the
      // second byte of the last pixel of each bar and is cleared in blanking
      // (H_BLANK >= 1 guarantees a clear before every line).
      if (hcnt >= HW'(HREF_LEN)) begin
        bar_pix <= '0;
        bar_idx <= '0;
      end else if (hcnt[0]) begin
        if (bar_pix == BW'(BAR_W - 1)) begin
          bar_pix <= '0;
          bar_idx <= bar_idx + 3'd1;
        end else begin
          bar_pix <= bar_pix + BW'(1);
        end
      end
    end
  end

  dvp_pattern_gen u_gen (
    .x     (12'(hcnt >> 1)),
    .y     (12'(vcnt)),
    .bar   (bar_idx),
    .pat   (pat_q),
    .solid (solid_q),
    .pix   (pix)
  );

  // Output decode
  always_comb begin
    vsynk_d = (state_q == ST_VSYNC);
    href_d  = in_href;
    data_d  = in_href ? pix_byte(pix, hcnt[0]) : '0;
    done_d  = (state_q == ST_VFP) && state_last;
    busy_d  = (state_q != ST_IDLE);
  end

  // Output registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cam.cam_vsynk <= 1'b0;
      cam.cam_href  <= 1'b0;
      cam.cam_data  <= '0;
      frame_done    <= 1'b0;
      frame_cnt     <= '0;
      busy          <= 1'b0;
    end else begin
      cam.cam_vsynk <= vsynk_d;
      cam.cam_href  <= href_d;
      cam.cam_data  <= data_d;
      frame_done    <= done_d;
      frame_cnt     <= frame_cnt + 16'(done_d);
      busy          <= busy_d;
    end
  end

endmodule

// File: tb/tb_dvp_pattern_tx.sv
module tb_dvp_pattern_tx;

  localparam int HA = 8, HB = 4, VS = 1, VBP = 1, VA = 2, VFP = 1;
  localparam int LINE  = 2 * HA + HB;
  localparam int FRAME = LINE * (VS + VBP + VA + VFP);

  logic        clk;
  logic        rstn;
  logic        enable;
  logic [1:0]  pattern_sel;
  logic [11:0] solid_rgb;
  logic        frame_done;
  logic [15:0] frame_cnt;
  logic        busy;

  dvp_pattern_tx_if cam_if ();

  dvp_pattern_tx #(
    .H_ACTIVE (HA),
    .H_BLANK  (HB),
    .V_SYNC   (VS),
    .V_BP     (VBP),
    .V_ACTIVE (VA),
    .V_FP     (VFP)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .enable      (enable),
    .pattern_sel (pattern_sel),
    .solid_rgb   (solid_rgb),
    .cam         (cam_if),
    .frame_done  (frame_done),
    .frame_cnt   (frame_cnt),
    .busy        (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected {vsynk, href, data, frame_done, busy} for frame position t
  // (clks since the frame was entered; -1 means idle), from the frame rules.
  function automatic logic [11:0] ref_vec(input int t, input int pat, input logic [11:0] solid);
    int          line, h, x, y, b;
    logic [11:0] w, xv, yv;
    logic [2:0]  bb;
    logic [7:0]  d;
    logic        vs, hr;
    if (t < 0) return 12'h000;
    line = t / LINE;
    h    = t % LINE;
    vs   = (line < VS);
    hr   = (line >= VS + VBP) && (line < VS + VBP + VA) && (h < 2 * HA);
    d    = 8'h00;
    if (hr) begin
      x  = h / 2;
      y  = line - VS - VBP;
      xv = 12'(x);
      yv = 12'(y);
      b  = x / (HA / 8);
      bb = 3'(b);
      case (pat)
        0:       w = {{4{bb[2]}}, {4{bb[1]}}, {4{bb[0]}}};
        1:       w = {xv[3:0], xv[7:4], yv[3:0]};
        2:       w = solid;
        default: w = 12'((x + y) % 4096);
      endcase
      d = (h % 2 == 0) ? {4'h0, w[3:0]} : {w[7:4], w[11:8]};
    end
    return {vs, hr, d, (t == FRAME - 1), 1'b1};
  endfunction

  // Reference model: frame position and latched settings, advanced per edge.
  int          m_t = -1;
  int          m_pat = 0;
  logic [11:0] m_solid = '0;
  logic [15:0] m_cnt = '0;
  logic [11:0] exp_vec = '0;

  initial begin
    forever begin
      @(posedge clk or negedge rstn);
      if (!rstn) begin
        m_t     = -1;
        m_cnt   = '0;
        exp_vec = '0;
      end else begin
        exp_vec = ref_vec(m_t, m_pat, m_solid);
        if (m_t == FRAME - 1) m_cnt = m_cnt + 16'd1;
        if (m_t == -1 || m_t == FRAME - 1) begin
          if (enable) begin
            m_t     = 0;
            m_pat   = int'(pattern_sel);
            m_solid = solid_rgb;
          end else begin
            m_t = -1;
          end
        end else begin
          m_t = m_t + 1;
        end
      end
    end
  end

  // Per-cycle comparison, away from the active edge
  initial begin
    forever begin
      @(negedge clk);
      check_eq("outputs", {cam_if.cam_vsynk, cam_if.cam_href, cam_if.cam_data, frame_done, busy}, exp_vec);
      check_eq("frame_cnt", frame_cnt, m_cnt);
    end
  end

  task automatic run_random(input int n);
    repeat (n) begin
      @(negedge clk);
      pattern_sel = 2'($urandom);
      solid_rgb   = 12'($urandom);
    end
  endtask

  initial begin
    int guard;
    rstn        = 1'b0;
    enable      = 1'b0;
    pattern_sel = 2'd0;
    solid_rgb   = 12'h000;
    repeat (3) @(negedge clk);
    rstn = 1'b1;

    // Idle with enable low
    repeat (200) @(negedge clk);
    check_eq("idle_busy", busy, 0);

    // Solid ABC; enable dropped once the first active line has started
    pattern_sel = 2'd2;
    solid_rgb   = 12'hABC;
    enable      = 1'b1;
    repeat (42) @(negedge clk);
    enable      = 1'b0;
    pattern_sel = 2'd0;
    solid_rgb   = 12'h000;
    repeat (120) @(negedge clk);
    check_eq("frame_cnt_1", frame_cnt, 16'd1);
    check_eq("back_idle", busy, 0);

    // Colour bars from a single-cycle enable
    pattern_sel = 2'd0;
    enable      = 1'b1;
    @(negedge clk);
    enable = 1'b0;
    repeat (110) @(negedge clk);

    // Back-to-back frames with inputs churning every cycle
    enable = 1'b1;
    run_random(300);

    // Counter wrap: preset to all-ones mid-frame
    @(negedge clk);
    #2 force dut.frame_cnt = 16'hFFFF;
    #1 release dut.frame_cnt;
    m_cnt = 16'hFFFF;
    check_eq("cnt_preset", frame_cnt, 16'hFFFF);
    run_random(150);
    enable = 1'b0;
    repeat (120) @(negedge clk);

    // Async reset in the middle of an active line
    pattern_sel = 2'd3;
    enable      = 1'b1;
    guard       = 0;
    while (cam_if.cam_href !== 1'b1 && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    check_eq("href_seen", cam_if.cam_href, 1);
    #2 rstn = 1'b0;
    #1;
    check_eq("rst_async", {cam_if.cam_vsynk, cam_if.cam_href, cam_if.cam_data, frame_done, busy}, 12'h000);
    check_eq("rst_cnt", frame_cnt, 16'd0);
    @(negedge clk);
    rstn = 1'b1;
    run_random(250);
    enable = 1'b0;
    repeat (120) @(negedge clk);
    check_eq("end_idle", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
